qs_srt_ucode_fetch: RTL
=======================

Name: qs_srt_ucode_fetch

Overview:
Microcode fetch stage for the quicksort sequencer. It sits directly upstream of the microcode control-store ROM. It owns the program counter and drives the ROM read address. It registers the returned instruction into a single-entry fetch register with a valid/ready handshake to the execute stage. Control-flow redirects (J/Jcc/CALL/RET) resolved in execute arrive on a redirect port, which reloads the PC and squashes the wrong-path entry.

Parameters:
PC_W, 8, program-counter width; matches the 8-bit AAAA_AAAA jump/call target field
INST_W, 16, microinstruction width
RESET_PC, 0, PC loaded on reset (the reset vector)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rom_ra  out  PC_W  control-store read address; combinational, equals pc_r
rom_rout  in  INST_W  control-store instruction for rom_ra; combinational, same cycle
fetch_vld_r  out  1  fetch register holds a valid instruction
fetch_inst_r  out  INST_W  fetched instruction
fetch_pc_r  out  PC_W  address of fetch_inst_r; execute uses it for CALL link values
fetch_jpred_r  out  1  fetch already took this unconditional J (optional feature); execute must not redirect on it
fetch_rdy  in  1  execute accepts fetch register this cycle
redirect_vld  in  1  execute requests PC reload
redirect_pc  in  PC_W  redirect target

Behaviour:
- Reset values:
  - pc_r = RESET_PC
  - fetch_vld_r = 0
  - fetch_inst_r = 0 (NOP)
  - fetch_pc_r = 0
  - fetch_jpred_r = 0
- rst has priority over every other input, including redirect_vld, and is honoured mid-operation.
- Transfer definition: fetch_vld_r & fetch_rdy & !redirect_vld.
- Advance condition: adv = !redirect_vld & (!fetch_vld_r | fetch_rdy).
- Per-cycle priority, highest first:
  1. rst: apply reset values.
  2. redirect_vld: pc_r <= redirect_pc; fetch_vld_r <= 0. The fetch register is squashed; fetch_rdy is ignored, so no transfer occurs.
  3. adv: fetch_inst_r <= rom_rout; fetch_pc_r <= pc_r; fetch_vld_r <= 1; pc_r <= pc_r + 1, modulo 2^PC_W (0xFF wraps to 0x00).
  4. Otherwise (stall): hold all state. rom_ra stays stable, so the ROM output is re-read unchanged.
- Two effective states, encoded by fetch_vld_r:
  - EMPTY → FULL on adv.
  - FULL → FULL on transfer or stall.
  - Any state → EMPTY on redirect.
- Latency:
  - After rst deasserts at cycle t, fetch_vld_r=1 with fetch_pc_r=RESET_PC at t+1.
  - Redirect at t: rom_ra=target at t+1 with fetch_vld_r=0 (one bubble); target instruction valid at t+2.
- Steady-state throughput: one instruction per cycle when fetch_rdy is held high.
- Back-to-back redirects: each redirect reloads the PC; only the last one takes effect. The register stays empty while redirect_vld is high.
- fetch_rdy is don't-care when fetch_vld_r=0.
- No combinational path from fetch_rdy/redirect_* to outputs other than through registers. rom_ra depends only on pc_r.

Optional Feature:
QS_SRT_FETCH_EARLY_JUMP_EN
- Defined:
  - Fetch pre-decodes rom_rout. Unconditional J is opcode 0001 with cc=00.
  - On adv of such an instruction, pc_r <= rom_rout[7:0] instead of pc_r+1, and fetch_jpred_r <= 1.
  - This removes the taken-jump bubble.
  - Redirect still has priority over the early jump.
  - Jcc with cc≠00, CALL and RET are not predicted.
- Undefined: fetch_jpred_r is tied to 0 and no pre-decode logic exists. Execute resolves every J.

Decomposition:
- Add to qs_srt_pkg:
  - pc_t and inst_t
  - opcode localparams (OP_NOP, OP_J, OP_CALL, …)
  - cc encoding (cc_t: UNCOND=00, EQ=01, GT=10, LE=11)
  - function is_uncond_j(inst_t)
  - RESET_PC
- One sub-module is natural: qs_srt_ucode_predecode, combinational. It takes an instruction and returns is_uncond_j and the jump target. It is instantiated only under the macro and is reusable by execute.
- The ROM is not instantiated here; the parent connects rom_ra/rom_rout.

Test Plan:
- Reset: rst=1 for 2 cycles → rom_ra=0, fetch_vld_r=0. Release with fetch_rdy=1 → next cycle fetch_vld_r=1, fetch_pc_r=0x00, fetch_inst_r=ROM[0x00]; then pc 0x01, 0x02… one per cycle.
- Backpressure: fetch_vld_r=1, fetch_pc_r=0x05; hold fetch_rdy=0 for 3 cycles → fetch_pc_r=0x05, fetch_inst_r and rom_ra=0x06 stable. Raise fetch_rdy → next cycle fetch_pc_r=0x06.
- Redirect: redirect_vld=1, redirect_pc=0x40 at t → t+1 fetch_vld_r=0, rom_ra=0x40; t+2 fetch_vld_r=1, fetch_pc_r=0x40, then 0x41.
- Redirect with fetch_rdy=1 in the same cycle, entry pc=0x2A → zero transfers counted by the scoreboard; entry squashed; next valid pc = redirect target.
- Wrap and reset mid-run:
  - pc_r=0xFF, advance → fetch_pc_r=0xFF, rom_ra=0x00.
  - Assert rst while fetch_vld_r=1 and redirect_vld=1 → next cycle reset values, rom_ra=RESET_PC.
- Early jump, ROM[0x00]=J 0x60 (0x1060):
  - Macro on → fetch_pc_r sequence 0x00 (jpred=1), 0x60 with no bubble.
  - Macro off → 0x00, 0x01, jpred=0.

Source files
------------

// File: rtl/qs_srt_pkg.sv
// ============================================================================
// Module : qs_srt_pkg
// Brief  : Shared types, opcode/cc encodings and helpers for the quicksort
//          sequencer microcode pipeline.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package qs_srt_pkg;

    typedef logic [7:0]  pc_t;
    typedef logic [15:0] inst_t;

    localparam pc_t RESET_PC = 8'h00;

    // Microinstruction layout: [15:12] opcode, [9:8] cc, [7:0] target/imm
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_J    = 4'h1;
    localparam logic [3:0] OP_CALL = 4'h2;
    localparam logic [3:0] OP_RET  = 4'h3;
    localparam logic [3:0] OP_LD   = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_CMP  = 4'h6;
    localparam logic [3:0] OP_SWAP = 4'h7;

    typedef enum logic [1:0] {
        UNCOND = 2'b00,
        EQ     = 2'b01,
        GT     = 2'b10,
        LE     = 2'b11
    } cc_t;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } fetch_state_t;

    function automatic logic is_uncond_j(input inst_t inst);
        return (inst[15:12] == OP_J) && (inst[9:8] == UNCOND);
    endfunction

endpackage : qs_srt_pkg

`default_nettype wire

// File: rtl/qs_srt_ucode_predecode.sv
// ============================================================================
// Module : qs_srt_ucode_predecode
// Brief  : Combinational pre-decode: flags an unconditional J and extracts
//          its target. Shared between fetch and execute.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module qs_srt_ucode_predecode
    import qs_srt_pkg::*;
(
    input  inst_t inst,
    output logic  uncond_j,
    output pc_t   target
);

    assign uncond_j = is_uncond_j(inst);
    assign target   = inst[7:0];

endmodule : qs_srt_ucode_predecode

`default_nettype wire

// File: rtl/qs_srt_ucode_fetch.sv
// ============================================================================
// Module : qs_srt_ucode_fetch
// Brief  : Microcode fetch stage: owns the PC, drives the control-store
//          address and holds one fetched instruction for execute.
//          Optional early-jump prediction: QS_SRT_FETCH_EARLY_JUMP_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module qs_srt_ucode_fetch #(
    parameter int          PC_W     = 8,
    parameter int          INST_W   = 16,
    parameter int unsigned RESET_PC = qs_srt_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   rom_ra,
    input  logic [INST_W-1:0] rom_rout,
    output logic              fetch_vld_r,
    output logic [INST_W-1:0] fetch_inst_r,
    output logic [PC_W-1:0]   fetch_pc_r,
    output logic              fetch_jpred_r,
    input  logic              fetch_rdy,
    input  logic              redirect_vld,
    input  logic [PC_W-1:0]   redirect_pc
);

    import qs_srt_pkg::*;

    localparam logic [PC_W-1:0] c_reset_pc = PC_W'(RESET_PC);

    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] w_pc_next_seq;
    logic            w_adv;
    logic            w_take_jump;
    fetch_state_t    state_r;
    fetch_state_t    w_state_next;

    assign rom_ra      = pc_r;
    assign fetch_vld_r = (state_r == ST_FULL);

`ifdef QS_SRT_FETCH_EARLY_JUMP_EN
    logic w_uncond_j;
    pc_t  w_jtarget;

    qs_srt_ucode_predecode u_predecode (
        .inst     (inst_t'(rom_rout)),
        .uncond_j (w_uncond_j),
        .target   (w_jtarget)
    );

    assign w_take_jump   = w_uncond_j;
    assign w_pc_next_seq = w_take_jump ? PC_W'(w_jtarget) : pc_r + 1'b1;

    logic jpred_r;
    always_ff @(posedge clk) begin
        if (rst) begin
            jpred_r <= 1'b0;
        end else if (redirect_vld) begin
            jpred_r <= 1'b0;
        end else if (w_adv) begin
            jpred_r <= w_take_jump;
        end
    end
    assign fetch_jpred_r = jpred_r;
`else
    assign w_take_jump   = 1'b0;
    assign w_pc_next_seq = pc_r + 1'b1;
    assign fetch_jpred_r = w_take_jump;
`endif

    // Stall keeps pc_r, so the ROM is simply re-read with the same address.
    always_comb begin
        w_adv        = !redirect_vld && ((state_r == ST_EMPTY) || fetch_rdy);
        w_state_next = state_r;
        if (redirect_vld) begin
            w_state_next = ST_EMPTY;
        end else if (w_adv) begin
            w_state_next = ST_FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r         <= c_reset_pc;
            fetch_inst_r <= '0;
            fetch_pc_r   <= '0;
        end else if (redirect_vld) begin
            pc_r <= redirect_pc;
        end else if (w_adv) begin
            fetch_inst_r <= rom_rout;
            fetch_pc_r   <= pc_r;
            pc_r         <= w_pc_next_seq;
        end
    end

endmodule : qs_srt_ucode_fetch

`default_nettype wire
